// File: rtl/cmos_frame_capture_pkg.sv
// Shared definitions for the OV7670 frame capture path: FSM encodings and pixel widths.
package cmos_frame_capture_pkg;

    localparam int BYTE_W   = 8;
    localparam int RGB565_W = 2 * BYTE_W;

    typedef enum logic [1:0] {
        ST_WAIT_INIT = 2'd0,
        ST_SKIP      = 2'd1,
        ST_WAIT_VS   = 2'd2,
        ST_CAPTURE   = 2'd3
    } cap_state_e;

endpackage

// File: rtl/cmos_frame_capture_sync_edge.sv
// Registers camera vsync/href; vsync gets a second stage for rising-edge detect,
// href gets a second stage for falling-edge detect (end of line).
module cmos_frame_capture_sync_edge
    import cmos_frame_capture_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic vsync_i,
    input  logic href_i,
    output logic vsync_r1_o,
    output logic href_r1_o,
    output logic vs_rise_o,
    output logic href_fall_o
);

    logic vsync_r1_q, vsync_r2_q;
    logic href_r1_q, href_r2_q;

    // Two-stage register of vsync and href.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_r1_q <= 1'b0;
            vsync_r2_q <= 1'b0;
            href_r1_q  <= 1'b0;
            href_r2_q  <= 1'b0;
        end else begin
            vsync_r1_q <= vsync_i;
            vsync_r2_q <= vsync_r1_q;
            href_r1_q  <= href_i;
            href_r2_q  <= href_r1_q;
        end
    end

    assign vsync_r1_o  = vsync_r1_q;
    assign href_r1_o   = href_r1_q;
    assign vs_rise_o   = vsync_r1_q & ~vsync_r2_q;
    assign href_fall_o = ~href_r1_q & href_r2_q;

endmodule

// File: rtl/cmos_frame_capture.sv
// OV7670 RGB565 byte stream to 16-bit pixel writes for the SDRAM write FIFO.
// Waits for SDRAM init, drops settling frames, clips to H_PIXELS x V_LINES.
//
// state      | meaning
// WAIT_INIT  | SDRAM not ready, nothing captured
// SKIP       | counting settling frames (vsync rising edges)
// WAIT_VS    | ready, waiting for the first captured frame start
// CAPTURE    | packing pixels; each vsync ends one frame and starts the next
module cmos_frame_capture
    import cmos_frame_capture_pkg::*;
#(
    parameter int H_PIXELS    = 640,
    parameter int V_LINES     = 480,
    parameter int SKIP_FRAMES = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                init_done,
    input  logic                cmos_vsync,
    input  logic                cmos_href,
    input  logic [BYTE_W-1:0]   cmos_data,
    output logic                sys_we,
    output logic [RGB565_W-1:0] sys_data_in,
    output logic                wr_load,
    output logic                frame_done,
    output logic                line_err
);

    localparam int PIX_W  = $clog2(H_PIXELS + 1);
    localparam int LINE_W = $clog2(V_LINES + 1);
    localparam int SKIP_W = $clog2(SKIP_FRAMES + 2);

    localparam logic [PIX_W-1:0]  H_MAX     = PIX_W'(H_PIXELS);
    localparam logic [LINE_W-1:0] V_MAX     = LINE_W'(V_LINES);
    localparam logic [SKIP_W-1:0] SKIP_LAST = SKIP_W'(SKIP_FRAMES - 1);

    logic vsync_r1, href_r1, vs_rise, href_fall;

    cmos_frame_capture_sync_edge u_sync (
        .clk         (clk),
        .rst_n       (rst_n),
        .vsync_i     (cmos_vsync),
        .href_i      (cmos_href),
        .vsync_r1_o  (vsync_r1),
        .href_r1_o   (href_r1),
        .vs_rise_o   (vs_rise),
        .href_fall_o (href_fall)
    );

    cap_state_e          state_q, state_d;
    logic [SKIP_W-1:0]   skip_q, skip_d;
    logic [BYTE_W-1:0]   data_r1_q;
    logic [BYTE_W-1:0]   hi_q, hi_d;
    logic                phase_q, phase_d;
    logic [PIX_W-1:0]    pix_q, pix_d;
    logic [LINE_W-1:0]   line_q, line_d;
    logic                we_q, we_d;
    logic [RGB565_W-1:0] data_q, data_d;
    logic                load_q, load_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                pack_en;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_WAIT_INIT;
        else        state_q <= state_d;
    end

    // Next-state logic; losing init_done always returns to WAIT_INIT.
    always_comb begin
        state_d = state_q;
        if (!init_done) begin
            state_d = ST_WAIT_INIT;
        end else begin
            unique case (state_q)
                ST_WAIT_INIT: state_d = ST_SKIP;
                ST_SKIP: begin
                    if (SKIP_FRAMES == 0)                     state_d = ST_WAIT_VS;
                    else if (vs_rise && skip_q == SKIP_LAST)  state_d = ST_WAIT_VS;
                end
                ST_WAIT_VS:   if (vs_rise) state_d = ST_CAPTURE;
                ST_CAPTURE:   state_d = ST_CAPTURE;
                default:      state_d = ST_WAIT_INIT;
            endcase
        end
    end

    // Output decode: frame-boundary pulses and packer enable.
    always_comb begin
        load_d  = init_done && vs_rise && (state_q == ST_WAIT_VS || state_q == ST_CAPTURE);
        done_d  = init_done && vs_rise && (state_q == ST_CAPTURE) && (line_q == V_MAX);
        pack_en = init_done && (state_q == ST_CAPTURE) && href_r1 && !vsync_r1;
    end

    // Skip counter, byte packer, pixel/line counters and line error.
    always_comb begin
        skip_d  = skip_q;
        hi_d    = hi_q;
        phase_d = phase_q;
        pix_d   = pix_q;
        line_d  = line_q;
        we_d    = 1'b0;
        data_d  = data_q;
        err_d   = err_q;

        if (state_q != ST_SKIP)  skip_d = '0;
        else if (vs_rise)        skip_d = skip_q + 1'b1;

        if (!init_done || state_q != ST_CAPTURE || vs_rise) begin
            phase_d = 1'b0;
            pix_d   = '0;
            line_d  = '0;
        end else if (href_fall) begin
            // An odd trailing byte is dropped by clearing the phase.
            if (phase_q || (pix_q < H_MAX && line_q < V_MAX)) err_d = 1'b1;
            phase_d = 1'b0;
            pix_d   = '0;
            if (line_q < V_MAX) line_d = line_q + 1'b1;
        end else if (pack_en) begin
            if (!phase_q) begin
                hi_d    = data_r1_q;
                phase_d = 1'b1;
            end else begin
                phase_d = 1'b0;
                if (pix_q < H_MAX) pix_d = pix_q + 1'b1;
                if (pix_q < H_MAX && line_q < V_MAX) begin
                    we_d   = 1'b1;
                    data_d = {hi_q, data_r1_q};
                end
            end
        end

        // wr_load clears the error, but a frame ending short re-flags it so the
        // short frame stays visible until the following wr_load.
        if (load_d) err_d = (state_q == ST_CAPTURE) && (line_q != V_MAX);
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skip_q    <= '0;
            data_r1_q <= '0;
            hi_q      <= '0;
            phase_q   <= 1'b0;
            pix_q     <= '0;
            line_q    <= '0;
            we_q      <= 1'b0;
            data_q    <= '0;
            load_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            skip_q    <= skip_d;
            data_r1_q <= cmos_data;
            hi_q      <= hi_d;
            phase_q   <= phase_d;
            pix_q     <= pix_d;
            line_q    <= line_d;
            we_q      <= we_d;
            data_q    <= data_d;
            load_q    <= load_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign sys_we      = we_q;
    assign sys_data_in = data_q;
    assign wr_load     = load_q;
    assign frame_done  = done_q;
    assign line_err    = err_q;

endmodule

// File: tb/tb_cmos_frame_capture.sv
// Directed bench for cmos_frame_capture with a reduced 4x3 frame and 2 skip frames.
module tb_cmos_frame_capture;

    localparam int H  = 4;
    localparam int V  = 3;
    localparam int SK = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        init_done = 1'b0;
    logic        cmos_vsync = 1'b0;
    logic        cmos_href = 1'b0;
    logic [7:0]  cmos_data = 8'h00;
    logic        sys_we;
    logic [15:0] sys_data_in;
    logic        wr_load;
    logic        frame_done;
    logic        line_err;

    cmos_frame_capture #(
        .H_PIXELS    (H),
        .V_LINES     (V),
        .SKIP_FRAMES (SK)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .init_done   (init_done),
        .cmos_vsync  (cmos_vsync),
        .cmos_href   (cmos_href),
        .cmos_data   (cmos_data),
        .sys_we      (sys_we),
        .sys_data_in (sys_data_in),
        .wr_load     (wr_load),
        .frame_done  (frame_done),
        .line_err    (line_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;
    int we_cnt = 0, wl_cnt = 0, fd_cnt = 0;
    int we0, wl0, fd0;

    // Pulse counters, sampled 1ns after each rising edge.
    always begin
        @(posedge clk);
        #1;
        if (sys_we)     we_cnt++;
        if (wr_load)    wl_cnt++;
        if (frame_done) fd_cnt++;
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic snap();
        we0 = we_cnt;
        wl0 = wl_cnt;
        fd0 = fd_cnt;
    endtask

    task automatic send_line(input int nb);
        for (int i = 0; i < nb; i++) begin
            cmos_href = 1'b1;
            cmos_data = 8'(i * 37 + 5);
            tick();
        end
        cmos_href = 1'b0;
        cmos_data = 8'h00;
        tick(3);
    endtask

    task automatic vs_pulse();
        cmos_vsync = 1'b1;
        tick(3);
        cmos_vsync = 1'b0;
        tick(3);
    endtask

    task automatic frame(input int nl, input int nb);
        vs_pulse();
        for (int l = 0; l < nl; l++) send_line(nb);
    endtask

    initial begin
        // reset state
        tick(2);
        chk("rst_we",   {31'd0, sys_we},     32'd0);
        chk("rst_data", {16'd0, sys_data_in}, 32'd0);
        chk("rst_wl",   {31'd0, wr_load},    32'd0);
        chk("rst_fd",   {31'd0, frame_done}, 32'd0);
        chk("rst_err",  {31'd0, line_err},   32'd0);
        rst_n = 1'b1;
        tick(2);
        init_done = 1'b1;
        tick(2);

        // settling frames dropped, third vsync starts capture
        snap();
        frame(V, 2 * H);
        frame(V, 2 * H);
        chk("skip_we", we_cnt - we0, 0);
        chk("skip_wl", wl_cnt - wl0, 0);
        snap();
        frame(V, 2 * H);
        chk("cap1_wl", wl_cnt - wl0, 1);
        chk("cap1_fd", fd_cnt - fd0, 0);
        chk("cap1_we", we_cnt - we0, H * V);
        snap();
        frame(V, 2 * H);
        chk("cap2_wl", wl_cnt - wl0, 1);
        chk("cap2_fd", fd_cnt - fd0, 1);
        chk("cap2_we", we_cnt - we0, H * V);
        chk("cap2_err", {31'd0, line_err}, 32'd0);
        snap();
        vs_pulse();
        chk("cap3_fd", fd_cnt - fd0, 1);

        // single pixel F8,1F with exact latency; short line flags error
        cmos_href = 1'b1;
        cmos_data = 8'hF8;
        tick();
        cmos_data = 8'h1F;
        tick();
        chk("pk_early", {31'd0, sys_we}, 32'd0);
        cmos_href = 1'b0;
        cmos_data = 8'h00;
        tick();
        chk("pk_we",   {31'd0, sys_we},     32'd1);
        chk("pk_data", {16'd0, sys_data_in}, 32'h0000F81F);
        tick();
        chk("pk_once", {31'd0, sys_we}, 32'd0);
        tick(2);
        chk("short_line_err", {31'd0, line_err}, 32'd1);

        // odd line clipped to H pixels, then extra line beyond V discarded
        snap();
        send_line(2 * H + 3);
        chk("odd_we", we_cnt - we0, H);
        send_line(2 * H);
        snap();
        send_line(2 * H);
        chk("clip_v_we", we_cnt - we0, 0);
        chk("err_sticky", {31'd0, line_err}, 32'd1);
        snap();
        vs_pulse();
        chk("long_fd", fd_cnt - fd0, 1);
        chk("long_wl", wl_cnt - wl0, 1);
        chk("err_clear", {31'd0, line_err}, 32'd0);

        // odd byte count alone sets line_err
        send_line(2 * H + 1);
        chk("odd_err", {31'd0, line_err}, 32'd1);
        send_line(2 * H);
        send_line(2 * H);
        snap();
        vs_pulse();
        chk("odd_fd", fd_cnt - fd0, 1);
        chk("odd_clr", {31'd0, line_err}, 32'd0);

        // short frame: wr_load only, error flagged
        send_line(2 * H);
        send_line(2 * H);
        snap();
        vs_pulse();
        chk("short_wl", wl_cnt - wl0, 1);
        chk("short_fd", fd_cnt - fd0, 0);
        chk("short_err", {31'd0, line_err}, 32'd1);

        // init_done dropped mid-line
        snap();
        for (int i = 0; i < 8; i++) begin
            if (i == 4) init_done = 1'b0;
            cmos_href = 1'b1;
            cmos_data = 8'(i + 8'h40);
            tick();
        end
        cmos_href = 1'b0;
        tick(3);
        chk("drop_we", we_cnt - we0, 1);
        snap();
        vs_pulse();
        send_line(2 * H);
        chk("drop_wl", wl_cnt - wl0, 0);
        chk("drop_fd", fd_cnt - fd0, 0);
        chk("drop_we2", we_cnt - we0, 0);

        // re-arm: settling frames again before capture
        init_done = 1'b1;
        tick(2);
        snap();
        frame(1, 2 * H);
        frame(1, 2 * H);
        chk("rearm_wl", wl_cnt - wl0, 0);
        chk("rearm_we", we_cnt - we0, 0);
        vs_pulse();
        chk("rearm_cap", wl_cnt - wl0, 1);
        send_line(2);
        chk("pre_rst_err", {31'd0, line_err}, 32'd1);

        // reset mid-line just before a pixel write would appear
        cmos_href = 1'b1;
        cmos_data = 8'hA0;
        tick();
        cmos_data = 8'hA1;
        tick();
        rst_n = 1'b0;
        cmos_data = 8'hA2;
        tick();
        chk("mrst_we",   {31'd0, sys_we},     32'd0);
        chk("mrst_data", {16'd0, sys_data_in}, 32'd0);
        chk("mrst_wl",   {31'd0, wr_load},    32'd0);
        chk("mrst_fd",   {31'd0, frame_done}, 32'd0);
        chk("mrst_err",  {31'd0, line_err},   32'd0);
        tick(2);
        cmos_href = 1'b0;
        rst_n = 1'b1;
        tick(3);
        snap();
        frame(1, 2 * H);
        frame(1, 2 * H);
        chk("post_rst_we", we_cnt - we0, 0);
        chk("post_rst_wl", wl_cnt - wl0, 0);
        snap();
        frame(1, 2 * H);
        chk("post_cap_wl", wl_cnt - wl0, 1);
        chk("post_cap_we", we_cnt - we0, H);

        tick(2);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
